ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_arbiter_if.sv | 47 ++++
 rtl/rr_pick2.sv | 23 ++
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding,
// RAM geometry and requester index constants.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int RAM_DEPTH = 64;
    localparam int RAM_IDX_W = $clog2(RAM_DEPTH);

    localparam int   NUM_REQ = 2;
    localparam logic REQ_A   = 1'b0;
    localparam logic REQ_B   = 1'b1;

    // With two requesters the round-robin successor is simply the other one.
    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-port bundle for ram_arbiter; slave is the arbiter side,
// master is the requesters plus the RAM.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic              rvalid_a;
    logic [DATA_W-1:0] rdata_a;
    logic              err_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_b;
    logic              err_b;

    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  ram_data_out,
        output gnt_a, rvalid_a, rdata_a, err_a,
        output gnt_b, rvalid_b, rdata_b, err_b,
        output ram_write_en, ram_address, ram_data_in
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output ram_data_out,
        input  gnt_a, rvalid_a, rdata_a, err_a,
        input  gnt_b, rvalid_b, rdata_b, err_b,
        input  ram_write_en, ram_address, ram_data_in
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req_a | req_b;
        winner = REQ_A;
        if (req_a && req_b) begin
            winner = other_req(last);
        end else if (req_b) begin
            winner = REQ_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one registered RAM port between two requesters.
// Define RAM_ARB_BOUNDS_EN to reject accesses outside the 64-word RAM.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);

    state_t state_reg, state_next;

    logic              last_reg, last_next;
    logic              owner_reg, owner_next;
    logic              lat_we_reg, lat_we_next;
    logic [ADDR_W-1:0] lat_addr_reg, lat_addr_next;
    logic [DATA_W-1:0] lat_wdata_reg, lat_wdata_next;
    logic              oob_reg, oob_next;

    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0] ram_din_reg, ram_din_next;

    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [NUM_REQ-1:0] rvalid_reg, rvalid_next;
    logic [NUM_REQ-1:0] err_reg, err_next;
    logic [DATA_W-1:0]  rdata_hold_reg [NUM_REQ];
    logic [DATA_W-1:0]  rdata_out      [NUM_REQ];

    logic [NUM_REQ-1:0] we_in;
    logic [ADDR_W-1:0]  addr_in  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_in [NUM_REQ];

    logic pick_winner;
    logic pick_valid;
    logic addr_oob;

    assign we_in           = {bus.we_b, bus.we_a};
    assign addr_in[REQ_A]  = bus.addr_a;
    assign addr_in[REQ_B]  = bus.addr_b;
    assign wdata_in[REQ_A] = bus.wdata_a;
    assign wdata_in[REQ_B] = bus.wdata_b;

    rr_pick2 u_pick (
        .req_a  (bus.req_a),
        .req_b  (bus.req_b),
        .last   (last_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

`ifdef RAM_ARB_BOUNDS_EN
    assign addr_oob = (lat_addr_reg >> RAM_IDX_W) != '0;
`else
    assign addr_oob = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // RAM controls are registered out of ISSUE, so the RAM samples them at the
    // end of the RESP cycle and its data is valid alongside the rvalid pulse.
    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        owner_next     = owner_reg;
        lat_we_next    = lat_we_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;
        oob_next       = oob_reg;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr_reg;
        ram_din_next   = ram_din_reg;
        gnt_next       = '0;
        rvalid_next    = '0;
        err_next       = '0;

        unique case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next            = pick_winner;
                    last_next             = pick_winner;
                    lat_we_next           = we_in[pick_winner];
                    lat_addr_next         = addr_in[pick_winner];
                    lat_wdata_next        = wdata_in[pick_winner];
                    gnt_next[pick_winner] = 1'b1;
                    state_next            = ISSUE;
                end
            end
            ISSUE: begin
                ram_addr_next = lat_addr_reg;
                ram_din_next  = lat_wdata_reg;
                ram_we_next   = lat_we_reg & ~addr_oob;
                oob_next      = addr_oob;
                state_next    = RESP;
            end
            RESP: begin
                rvalid_next[owner_reg] = 1'b1;
                err_next[owner_reg]    = oob_reg;
                state_next             = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg      <= REQ_B;
            owner_reg     <= REQ_A;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            oob_reg       <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_din_reg   <= '0;
            gnt_reg       <= '0;
            rvalid_reg    <= '0;
            err_reg       <= '0;
        end else begin
            last_reg      <= last_next;
            owner_reg     <= owner_next;
            lat_we_reg    <= lat_we_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
            oob_reg       <= oob_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_din_reg   <= ram_din_next;
            gnt_reg       <= gnt_next;
            rvalid_reg    <= rvalid_next;
            err_reg       <= err_next;
        end
    end

    // Response data passes straight through from the RAM during the pulse and
    // is captured so rdata stays stable until the next response.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign rdata_out[gi] = rvalid_reg[gi] ? (err_reg[gi] ? '0 : bus.ram_data_out)
                                                  : rdata_hold_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_hold_reg[gi] <= '0;
                end else if (rvalid_reg[gi]) begin
                    rdata_hold_reg[gi] <= rdata_out[gi];
                end
            end
        end
    endgenerate

    assign bus.gnt_a    = gnt_reg[REQ_A];
    assign bus.gnt_b    = gnt_reg[REQ_B];
    assign bus.rvalid_a = rvalid_reg[REQ_A];
    assign bus.rvalid_b = rvalid_reg[REQ_B];
    assign bus.err_a    = err_reg[REQ_A];
    assign bus.err_b    = err_reg[REQ_B];
    assign bus.rdata_a  = rdata_out[REQ_A];
    assign bus.rdata_b  = rdata_out[REQ_B];

    assign bus.ram_write_en = ram_we_reg;
    assign bus.ram_address  = ram_addr_reg;
    assign bus.ram_data_in  = ram_din_reg;

endmodule
